// File: rtl/sum_disp_pkg.sv
// Shared definitions for the sum-to-BCD display stage: FSM encoding,
// seven-segment codes (active-low, {g,f,e,d,c,b,a}) and the BCD width.
package sum_disp_pkg;

    localparam int BCD_W = 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/sum_bcd_display_if.sv
// Valid/ready link carrying the binary sum from the adder stage.
interface sum_bcd_display_if #(
    parameter int SUM_W = 6
);
    logic [SUM_W-1:0] sum_in;
    logic             sum_valid;
    logic             sum_ready;

    modport master (output sum_in, output sum_valid, input sum_ready);
    modport slave  (input sum_in, input sum_valid, output sum_ready);
endinterface

// File: rtl/seg7_decode.sv
// One BCD nibble to active-low seven-segment pattern; codes 10..15 blank.
module seg7_decode
    import sum_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: default assignment first so no path through the block leaves seg unassigned (no latch).
        seg = SEG_BLANK;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sum_bcd_display.sv
// Binary sum -> two BCD digits via sequential double-dabble -> HEX1/HEX0.
// Optional SUM_LEADING_ZERO_BLANK_EN blanks HEX1 when the tens digit is zero.
module sum_bcd_display
    import sum_disp_pkg::*;
#(
    parameter int SUM_W = 6
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    sum_bcd_display_if.slave     bus,
    output logic                 disp_done,
    output logic [BCD_W-1:0]     bcd_out,
    output logic [6:0]           HEX0,
    output logic [6:0]           HEX1
);

    localparam int SR_W  = BCD_W + SUM_W;
    localparam int CNT_W = $clog2(SUM_W + 1);

    logic [1:0]       state;
    logic [SR_W-1:0]  shreg;
    logic [SR_W-1:0]  shreg_adj;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       tens;
    logic [3:0]       units;
    logic [6:0]       seg_tens;
    logic [6:0]       seg_units;
    logic [6:0]       hex1_next;
    logic             transfer;

    assign bus.sum_ready = (state == IDLE);
    assign transfer      = bus.sum_valid && bus.sum_ready;

    // BCD digits sit directly above the binary field in the shift register.
    assign units = shreg[SUM_W +: 4];
    assign tens  = shreg[SUM_W+4 +: 4];

    always_comb begin
        shreg_adj = shreg;
        if (units >= 4'd5) shreg_adj[SUM_W +: 4]   = units + 4'd3;
        if (tens  >= 4'd5) shreg_adj[SUM_W+4 +: 4] = tens + 4'd3;
    end

    seg7_decode u_dec_units (.nibble(units), .seg(seg_units));
    seg7_decode u_dec_tens  (.nibble(tens),  .seg(seg_tens));

`ifdef SUM_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] HEX1_RST = SEG_BLANK;
    assign hex1_next = (tens == 4'd0) ? SEG_BLANK : seg_tens;
`else
    localparam logic [6:0] HEX1_RST = SEG_0;
    assign hex1_next = seg_tens;
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            disp_done <= 1'b0;
            bcd_out   <= '0;
            HEX0      <= SEG_0;
            HEX1      <= HEX1_RST;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            disp_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (transfer) begin
                        shreg <= {{BCD_W{1'b0}}, bus.sum_in};
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg <= {shreg_adj[SR_W-2:0], 1'b0};
                    if (cnt == CNT_W'(SUM_W - 1)) state <= UPDATE;
                    else                          cnt   <= cnt + 1'b1;
                end
                UPDATE: begin
                    // Outputs change only here, so partial digits are never shown.
                    bcd_out   <= {tens, units};
                    HEX0      <= seg_units;
                    HEX1      <= hex1_next;
                    disp_done <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_bcd_display.sv
// Self-checking bench for sum_bcd_display: vector table plus scoreboard of expected displays.
module tb_sum_bcd_display;

    localparam int SUM_W = 6;

`ifdef SUM_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct {
        logic [5:0] sum;
        logic [7:0] bcd;
        logic [6:0] hex1;
        logic [6:0] hex0;
    } vec_t;

    typedef struct {
        logic [7:0] bcd;
        logic [6:0] hex1;
        logic [6:0] hex0;
        int         t;
    } exp_t;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b1;
    logic       disp_done;
    logic [7:0] bcd_out;
    logic [6:0] HEX0;
    logic [6:0] HEX1;

    sum_bcd_display_if #(.SUM_W(SUM_W)) bus ();

    sum_bcd_display #(.SUM_W(SUM_W)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .bus       (bus),
        .disp_done (disp_done),
        .bcd_out   (bcd_out),
        .HEX0      (HEX0),
        .HEX1      (HEX1)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    exp_t q[$];
    exp_t mon_e;
    vec_t tbl[12];

    logic [6:0] hex1_rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t lookup(input logic [5:0] s);
        vec_t v;
        v = tbl[0];
        foreach (tbl[i]) if (tbl[i].sum == s) v = tbl[i];
        return v;
    endfunction

    task automatic push(input vec_t v, input int t);
        exp_t e;
        e.bcd  = v.bcd;
        e.hex0 = v.hex0;
        e.hex1 = (LZB && v.bcd[7:4] == 4'd0) ? 7'h7F : v.hex1;
        e.t    = t;
        q.push_back(e);
    endtask

    task automatic send(input logic [5:0] s);
        int n = 0;
        @(negedge CLOCK_50);
        while (!bus.sum_ready && n < 40) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (!bus.sum_ready) begin
            check("ready_timeout", 32'(bus.sum_ready), 32'd1);
        end else begin
            bus.sum_in    = s;
            bus.sum_valid = 1'b1;
            push(lookup(s), cyc + 1);
            @(posedge CLOCK_50);
            #1 bus.sum_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        @(negedge CLOCK_50);
        check("drain", q.size(), 32'd0);
    endtask

    always @(posedge CLOCK_50) cyc++;

    // Scoreboard: each disp_done pulse retires the oldest expected display.
    always @(negedge CLOCK_50) begin
        if (disp_done === 1'b1) begin
            done_cnt++;
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("bcd_out", bcd_out, mon_e.bcd);
                check("HEX0", HEX0, mon_e.hex0);
                check("HEX1", HEX1, mon_e.hex1);
                check("latency", cyc - mon_e.t, 32'd7);
            end
        end
    end

    initial begin
        int d0;
        int t0;

        tbl[0]  = '{6'd42, 8'h42, 7'h19, 7'h24};
        tbl[1]  = '{6'd63, 8'h63, 7'h02, 7'h30};
        tbl[2]  = '{6'd0,  8'h00, 7'h40, 7'h40};
        tbl[3]  = '{6'd5,  8'h05, 7'h40, 7'h12};
        tbl[4]  = '{6'd17, 8'h17, 7'h79, 7'h78};
        tbl[5]  = '{6'd38, 8'h38, 7'h30, 7'h00};
        tbl[6]  = '{6'd9,  8'h09, 7'h40, 7'h10};
        tbl[7]  = '{6'd10, 8'h10, 7'h79, 7'h40};
        tbl[8]  = '{6'd59, 8'h59, 7'h12, 7'h10};
        tbl[9]  = '{6'd1,  8'h01, 7'h40, 7'h79};
        tbl[10] = '{6'd50, 8'h50, 7'h12, 7'h40};
        tbl[11] = '{6'd31, 8'h31, 7'h30, 7'h79};
        hex1_rst = LZB ? 7'h7F : 7'h40;

        bus.sum_in    = '0;
        bus.sum_valid = 1'b0;

        // Reset state
        #2 RESET_N = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        check("rst_ready", 32'(bus.sum_ready), 32'd1);
        check("rst_done", 32'(disp_done), 32'd0);
        check("rst_bcd", bcd_out, 32'h00);
        check("rst_HEX0", HEX0, 32'h40);
        check("rst_HEX1", HEX1, hex1_rst);
        RESET_N = 1'b1;
        @(negedge CLOCK_50);
        check("rel_ready", 32'(bus.sum_ready), 32'd1);
        check("rel_HEX0", HEX0, 32'h40);

        // 42: ready low for seven edges, one disp_done pulse
        d0 = done_cnt;
        send(6'd42);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK_50);
            check("ready_profile", 32'(bus.sum_ready), (i == 7) ? 32'd1 : 32'd0);
        end
        wait_drain();
        check("done_pulses_42", done_cnt - d0, 32'd1);

        // 63 then 0 with sum_valid held high; second accepted at edge 8
        @(negedge CLOCK_50);
        bus.sum_in    = 6'd63;
        bus.sum_valid = 1'b1;
        t0 = cyc + 1;
        push(lookup(6'd63), t0);
        @(posedge CLOCK_50);
        #1 bus.sum_in = 6'd0;
        push(lookup(6'd0), t0 + 8);
        repeat (8) @(posedge CLOCK_50);
        #1 bus.sum_valid = 1'b0;
        wait_drain();

        // Single-digit value: leading-zero handling on HEX1
        send(6'd5);
        wait_drain();

        // 17 with a stray valid pulse and new data mid-conversion
        send(6'd17);
        @(negedge CLOCK_50);
        bus.sum_in    = 6'd3;
        bus.sum_valid = 1'b1;
        @(posedge CLOCK_50);
        #1 bus.sum_valid = 1'b0;
        bus.sum_in = 6'd50;
        wait_drain();

        // Table sweep, issued as fast as sum_ready allows
        foreach (tbl[i]) send(tbl[i].sum);
        wait_drain();

        // Reset at edge 3 of a conversion aborts it
        d0 = done_cnt;
        send(6'd42);
        repeat (3) @(posedge CLOCK_50);
        RESET_N = 1'b0;
        q.delete();
        #1;
        check("abort_ready", 32'(bus.sum_ready), 32'd1);
        check("abort_bcd", bcd_out, 32'h00);
        check("abort_HEX0", HEX0, 32'h40);
        check("abort_HEX1", HEX1, hex1_rst);
        repeat (4) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        check("abort_no_done", done_cnt - d0, 32'd0);

        send(6'd38);
        wait_drain();
        check("queue_empty", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
